// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag bit positions for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] ADD     = 4'd0;
  localparam logic [3:0] NEGA    = 4'd1;
  localparam logic [3:0] AND     = 4'd2;
  localparam logic [3:0] OR      = 4'd3;
  localparam logic [3:0] XOR     = 4'd4;
  localparam logic [3:0] INVA    = 4'd5;
  localparam logic [3:0] SELAB   = 4'd6;
  localparam logic [3:0] SELBA   = 4'd7;
  localparam logic [3:0] SUB     = 4'd8;
  localparam logic [3:0] ALTB    = 4'd9;
  localparam logic [3:0] ALTEB   = 4'd10;
  localparam logic [3:0] AGTB    = 4'd11;
  localparam logic [3:0] AGTEB   = 4'd12;
  localparam logic [3:0] AEQB    = 4'd13;
  localparam logic [3:0] ANEQB   = 4'd14;
  localparam logic [3:0] SELXORB = 4'd15;

  localparam int FLAG_C  = 3;
  localparam int FLAG_V  = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_ZF = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: 16 opcodes, selectable compare signedness,
// carry/overflow/negative/zero flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       inst,
  input  logic             sel,
  output logic [WIDTH-1:0] z,
  output logic [3:0]       flags
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ONE_X   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int               MSB     = WIDTH - 1;

  logic [WIDTH:0]          sum;
  logic [WIDTH:0]          dif;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    lt;
  logic                    eq;
  logic                    c;
  logic                    v;

  assign a_s = a;
  assign b_s = b;
  assign sum = {1'b0, a} + {1'b0, b};
  // Subtraction as A + ~B + 1 so the carry out reads as "no borrow".
  assign dif = {1'b0, a} + {1'b0, ~b} + ONE_X;
  assign eq  = (a == b);
  assign lt  = SIGNED_CMP ? (a_s < b_s) : (a < b);

  always_comb begin
    z = '0;
    c = 1'b0;
    v = 1'b0;
    case (inst)
      ADD: begin
        z = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      NEGA: begin
        z = ~a + ONE;
        v = (a == MIN_NEG);
      end
      AND:     z = a & b;
      OR:      z = a | b;
      XOR:     z = a ^ b;
      INVA:    z = ~a;
      SELAB:   z = sel ? b : a;
      SELBA:   z = sel ? a : b;
      SUB: begin
        z = dif[WIDTH-1:0];
        c = dif[WIDTH];
        v = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
      end
      ALTB:    z = {{(WIDTH-1){1'b0}}, lt};
      ALTEB:   z = {{(WIDTH-1){1'b0}}, lt | eq};
      AGTB:    z = {{(WIDTH-1){1'b0}}, ~(lt | eq)};
      AGTEB:   z = {{(WIDTH-1){1'b0}}, ~lt};
      AEQB:    z = {{(WIDTH-1){1'b0}}, eq};
      ANEQB:   z = {{(WIDTH-1){1'b0}}, ~eq};
      SELXORB: z = b ^ {{(WIDTH-1){1'b0}}, sel};
      default: z = '0;
    endcase
  end

  assign flags[FLAG_C]  = c;
  assign flags[FLAG_V]  = v;
  assign flags[FLAG_N]  = z[MSB];
  assign flags[FLAG_ZF] = ~|z;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU: operand register, alu_core, result
// register, with full backpressure on both handshakes.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int TAG_W      = 4,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       INST,
  input  logic             SEL,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Z,
  output logic [3:0]       FLAGS,
  output logic [TAG_W-1:0] OUT_TAG
);

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [3:0]       inst_p1;
  logic             sel_p1;
  logic [TAG_W-1:0] tag_p1;
  logic [WIDTH-1:0] z_p1;
  logic [3:0]       flags_p1;
  logic             rdy_p1;

  logic             vld_p2;
  logic [WIDTH-1:0] z_p2;
  logic [3:0]       flags_p2;
  logic [TAG_W-1:0] tag_p2;
  logic             rdy_p2;

  assign rdy_p2   = !vld_p2 || OUT_READY;
  assign rdy_p1   = !vld_p1 || rdy_p2;
  assign IN_READY = rst_n && rdy_p1;

  // Stage 1: operand capture on the input handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (rdy_p1) begin
      vld_p1 <= IN_VALID;
    end
  end

  always_ff @(posedge clk) begin
    if (IN_VALID && IN_READY) begin
      a_p1    <= A;
      b_p1    <= B;
      inst_p1 <= INST;
      sel_p1  <= SEL;
      tag_p1  <= IN_TAG;
    end
  end

  alu_core #(
    .WIDTH      (WIDTH),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_core (
    .a     (a_p1),
    .b     (b_p1),
    .inst  (inst_p1),
    .sel   (sel_p1),
    .z     (z_p1),
    .flags (flags_p1)
  );

  // Stage 2: result register; cleared on reset so the result bus idles at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      z_p2     <= '0;
      flags_p2 <= '0;
      tag_p2   <= '0;
    end else if (rdy_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        z_p2     <= z_p1;
        flags_p2 <= flags_p1;
        tag_p2   <= tag_p1;
      end
    end
  end

  assign OUT_VALID = vld_p2;
  assign Z         = z_p2;
  assign FLAGS     = flags_p2;
  assign OUT_TAG   = tag_p2;

endmodule
